// File: rtl/flash_copier.sv
// Copies N_WORDS 32-bit words from an Avalon-MM flash slave into a sample memory,
// splitting each word into 32/SAMPLE_W samples written on consecutive cycles.
module flash_copier #(
  parameter int FLASH_AW  = 23,
  parameter int MEM_AW    = 8,
  parameter int SAMPLE_W  = 16,
  parameter int N_WORDS   = 128,
  parameter int BASE_ADDR = 0,
  parameter int HI_FIRST  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                flash_mem_read,
  output logic [FLASH_AW-1:0] flash_mem_address,
  output logic [3:0]          flash_mem_byteenable,
  input  logic                flash_mem_waitrequest,
  input  logic [31:0]         flash_mem_readdata,
  input  logic                flash_mem_readdatavalid,
  output logic [MEM_AW-1:0]   s_addr,
  output logic [SAMPLE_W-1:0] s_wrdata,
  output logic                s_wren
);

  localparam int SPW = 32 / SAMPLE_W;
  localparam logic [1:0]          K_LAST    = 2'(SPW - 1);
  localparam logic [31:0]         WORD_LAST = 32'(N_WORDS - 1);
  localparam logic [FLASH_AW-1:0] FA_ONE    = FLASH_AW'(1);
  localparam logic [FLASH_AW-1:0] FA_BASE   = FLASH_AW'(BASE_ADDR);
  localparam logic [MEM_AW-1:0]   MA_ONE    = MEM_AW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t              state_r;
  logic [31:0]         buf_r;
  logic [31:0]         word_cnt_r;
  logic [MEM_AW-1:0]   ptr_r;
  logic [1:0]          k_r;

  // Slice idx in write order; HI_FIRST reverses the order to MSB slice first.
  function automatic logic [SAMPLE_W-1:0] slice_of(input logic [31:0] w, input int idx);
    int pos;
    pos = (HI_FIRST != 0) ? (SPW - 1 - idx) : idx;
    return w[pos*SAMPLE_W +: SAMPLE_W];
  endfunction

  assign flash_mem_byteenable = 4'b1111;

  // Copy sequencer: every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
      s_addr            <= '0;
      s_wrdata          <= '0;
      s_wren            <= 1'b0;
      buf_r             <= 32'd0;
      word_cnt_r        <= 32'd0;
      ptr_r             <= '0;
      k_r               <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            flash_mem_address <= FA_BASE;
            word_cnt_r        <= 32'd0;
            ptr_r             <= '0;
            k_r               <= 2'd0;
            busy              <= 1'b1;
            flash_mem_read    <= 1'b1;
            state_r           <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (!flash_mem_waitrequest) begin
            flash_mem_read <= 1'b0;
            state_r        <= WAIT;
          end else begin
            flash_mem_read <= 1'b1;
          end
        end
        WAIT: begin
          // The first slice is taken straight from readdata so WRITE lasts exactly SPW cycles.
          if (flash_mem_readdatavalid) begin
            buf_r    <= flash_mem_readdata;
            k_r      <= 2'd0;
            s_wren   <= 1'b1;
            s_addr   <= ptr_r;
            s_wrdata <= slice_of(flash_mem_readdata, 0);
            ptr_r    <= ptr_r + MA_ONE;
            state_r  <= WRITE;
          end else begin
            state_r <= WAIT;
          end
        end
        WRITE: begin
          if (k_r == K_LAST) begin
            s_wren   <= 1'b0;
            s_wrdata <= '0;
            if (word_cnt_r == WORD_LAST) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= FIN;
            end else begin
              flash_mem_address <= flash_mem_address + FA_ONE;
              word_cnt_r        <= word_cnt_r + 32'd1;
              flash_mem_read    <= 1'b1;
              state_r           <= REQ;
            end
          end else begin
            k_r      <= k_r + 2'd1;
            s_addr   <= ptr_r;
            s_wrdata <= slice_of(buf_r, int'(k_r) + 1);
            ptr_r    <= ptr_r + MA_ONE;
          end
        end
        FIN: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r        <= IDLE;
          busy           <= 1'b0;
          done           <= 1'b0;
          flash_mem_read <= 1'b0;
          s_wren         <= 1'b0;
          s_wrdata       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_copier.sv
// Directed bench for flash_copier: default 16-bit build against a flash model with
// programmable stall/latency, plus an 8-bit MSB-first build copying two words.
module tb_flash_copier;

  logic        clk = 1'b0;
  logic        rst, start, spur;
  logic        busy, done, rd, be_unused_s;
  logic [22:0] addr;
  logic [3:0]  be;
  logic        waitreq, rdv;
  logic [31:0] rdata;
  logic [7:0]  s_addr;
  logic [15:0] s_wrdata;
  logic        s_wren;

  logic        start8, busy8, done8, rd8, rdv8;
  logic [22:0] addr8;
  logic [3:0]  be8;
  logic [31:0] rdata8;
  logic [7:0]  s_addr8;
  logic [7:0]  s_wrdata8;
  logic        s_wren8;

  int stall_cfg = 0, lat_cfg = 1;
  int stall_used = 0, pend_cnt = 0;
  logic [22:0] pend_addr = 23'd0;
  logic        rdv_r = 1'b0;
  logic [31:0] rdata_r = 32'd0;
  int nreads = 0, nwrites = 0, bad_wr = 0, nz_wr = 0, ndone = 0;
  logic [15:0] smem [0:255];
  int wcnt8 = 0, ndone8 = 0;
  logic [7:0]  mem8 [0:7];

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  flash_copier dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .flash_mem_read(rd), .flash_mem_address(addr), .flash_mem_byteenable(be),
    .flash_mem_waitrequest(waitreq), .flash_mem_readdata(rdata),
    .flash_mem_readdatavalid(rdv), .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  flash_copier #(.SAMPLE_W(8), .HI_FIRST(1), .N_WORDS(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .flash_mem_read(rd8), .flash_mem_address(addr8), .flash_mem_byteenable(be8),
    .flash_mem_waitrequest(1'b0), .flash_mem_readdata(rdata8),
    .flash_mem_readdatavalid(rdv8), .s_addr(s_addr8), .s_wrdata(s_wrdata8), .s_wren(s_wren8)
  );

  function automatic logic [31:0] word_of(input logic [22:0] a);
    return {16'(2 * a + 1), 16'(2 * a)};
  endfunction

  assign waitreq = rd && (stall_used < stall_cfg);
  assign rdv     = rdv_r | spur;
  assign rdata   = rdata_r;
  assign be_unused_s = |be8;

  // Flash slave model for the default build.
  always @(posedge clk) begin
    rdv_r   <= 1'b0;
    rdata_r <= 32'd0;
    if (pend_cnt == 1) begin
      rdv_r   <= 1'b1;
      rdata_r <= word_of(pend_addr);
    end
    if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
    if (rd && !waitreq) begin
      nreads     <= nreads + 1;
      stall_used <= 0;
      if (lat_cfg <= 1) begin
        rdv_r   <= 1'b1;
        rdata_r <= word_of(addr);
      end else begin
        pend_cnt  <= lat_cfg - 1;
        pend_addr <= addr;
      end
    end else if (rd) begin
      stall_used <= stall_used + 1;
    end
  end

  // Sample memory and write/done scoreboard for the default build.
  always @(posedge clk) begin
    if (done) ndone <= ndone + 1;
    if (s_wren) begin
      smem[s_addr] <= s_wrdata;
      nwrites      <= nwrites + 1;
      if (s_wrdata !== 16'(s_addr)) bad_wr <= bad_wr + 1;
    end else if (s_wrdata !== 16'd0) begin
      nz_wr <= nz_wr + 1;
    end
  end

  // Zero-wait, one-cycle-latency slave and sample memory for the 8-bit build.
  always @(posedge clk) begin
    rdv8   <= rd8;
    rdata8 <= rd8 ? (addr8[0] ? 32'h11223344 : 32'hAABBCCDD) : 32'd0;
    if (done8) ndone8 <= ndone8 + 1;
    if (s_wren8) begin
      wcnt8 <= wcnt8 + 1;
      if (s_addr8 < 8'd8) mem8[s_addr8[2:0]] <= s_wrdata8;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int lim, input int poke, input int cyc_in, output int cyc);
    cyc = cyc_in;
    while (done !== 1'b1 && cyc < lim) begin
      start = (cyc == poke) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
  endtask

  task automatic run_to_done(input int lim, input int poke, output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lim, poke, 1, cyc);
  endtask

  initial begin
    int cyc, r0, w0, d0, hc, moved, t;
    logic [22:0] a0;
    rst = 1'b1; start = 1'b0; spur = 1'b0; start8 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, with start asserted alongside reset.
    start = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_read", rd, 1'b0);
    check("rst_addr", addr, 23'd0);
    check("byteenable", be, 4'hF);
    check("rst_wren", s_wren, 1'b0);
    check("rst_wrdata", s_wrdata, 16'd0);
    check("rst_saddr", s_addr, 8'd0);
    check("rst_busy8", busy8, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", busy, 1'b0);

    // Full default run, no stalls.
    r0 = nreads; w0 = nwrites; d0 = ndone;
    run_to_done(2000, 0, cyc);
    check("run1_done_cycle", cyc, 513);
    check("run1_busy_at_done", busy, 1'b0);
    @(negedge clk);
    check("run1_done_pulse", done, 1'b0);
    check("run1_reads", nreads - r0, 128);
    check("run1_writes", nwrites - w0, 256);
    check("run1_ndone", ndone - d0, 1);
    check("run1_bad_wr", bad_wr, 0);
    check("smem0", smem[0], 16'd0);
    check("smem129", smem[129], 16'd129);
    check("smem255", smem[255], 16'd255);

    // Waitrequest stalls: read held 6 cycles with stable address.
    stall_cfg = 5;
    r0 = nreads; w0 = nwrites;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a0 = addr; hc = 0; moved = 0;
    while (rd && hc < 20) begin
      if (addr !== a0) moved++;
      hc++;
      @(negedge clk);
    end
    check("stall_read_cycles", hc, 6);
    check("stall_addr_moved", moved, 0);
    check("stall_one_read", nreads - r0, 1);
    wait_done(3000, 0, hc + 1, cyc);
    check("stall_reads", nreads - r0, 128);
    check("stall_writes", nwrites - w0, 256);
    check("stall_bad_wr", bad_wr, 0);
    stall_cfg = 0;
    @(negedge clk);

    // Spurious readdatavalid in IDLE, then a run with 10-cycle latency.
    lat_cfg = 10;
    w0 = nwrites;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_writes", nwrites - w0, 0);
    check("spur_busy", busy, 1'b0);
    r0 = nreads; d0 = ndone;
    run_to_done(3000, 0, cyc);
    check("lat_done_cycle", cyc, 128 * 13 + 1);
    @(negedge clk);
    check("lat_writes", nwrites - w0, 256);
    check("lat_ndone", ndone - d0, 1);
    check("lat_bad_wr", bad_wr, 0);
    lat_cfg = 1;

    // Start pulses mid-run and in FIN are ignored.
    r0 = nreads; d0 = ndone;
    run_to_done(2000, 100, cyc);
    check("restart_done_cycle", cyc, 513);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fin_start_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("fin_start_read", rd, 1'b0);
    check("restart_reads", nreads - r0, 128);
    check("restart_ndone", ndone - d0, 1);

    // Reset during the third WAIT, then a fresh run.
    lat_cfg = 10;
    r0 = nreads; d0 = ndone;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (nreads - r0 < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("third_read", nreads - r0, 3);
    check("in_wait_read", rd, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_read", rd, 1'b0);
    check("mid_rst_addr", addr, 23'd0);
    check("mid_rst_wren", s_wren, 1'b0);
    check("mid_rst_saddr", s_addr, 8'd0);
    check("mid_rst_wrdata", s_wrdata, 16'd0);
    w0 = nwrites;
    repeat (15) @(negedge clk);
    check("post_rst_writes", nwrites - w0, 0);
    check("post_rst_ndone", ndone - d0, 0);
    lat_cfg = 1;
    r0 = nreads;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fresh_addr", addr, 23'd0);
    check("fresh_read", rd, 1'b1);
    wait_done(2000, 0, 1, cyc);
    @(negedge clk);
    check("fresh_reads", nreads - r0, 128);
    check("fresh_writes", nwrites - w0, 256);
    check("fresh_ndone", ndone - d0, 1);
    check("fresh_bad_wr", bad_wr, 0);
    check("wrdata_idle_zero", nz_wr, 0);

    // 8-bit samples, MSB slice first, two words.
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    t = 0;
    while (done8 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("w8_done_seen", done8, 1'b1);
    repeat (3) @(negedge clk);
    check("w8_writes", wcnt8, 8);
    check("w8_ndone", ndone8, 1);
    check("w8_m0", mem8[0], 8'hAA);
    check("w8_m1", mem8[1], 8'hBB);
    check("w8_m2", mem8[2], 8'hCC);
    check("w8_m3", mem8[3], 8'hDD);
    check("w8_m4", mem8[4], 8'h11);
    check("w8_m7", mem8[7], 8'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
